// File: rtl/acc_cpu_hs.sv
// acc_cpu_hs - parametrised accumulator CPU with req/ack memory handshake.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   mem_req/we/addr/wdata  memory request, held stable until the acked edge
//   mem_rdata, mem_ack     read data and completion strobe from memory
//   AC, PC, IR             accumulator, program counter, instruction register
//   Carry/Zero/Overflow/Negative  status flags, updated by EXEC only
//   halted                 core stopped (HALT opcode or trap)
//   illegal_op             sticky illegal-opcode trap flag
//   state                  FSM state, debug only
//
// Optional build macro ILLEGAL_TRAP_EN: opcodes D/E halt the core and raise
// illegal_op. Without it D/E behave as NOP and illegal_op is tied low.
//
// Instruction: opcode=IR[DATA_W-1 -: 4], mode=IR[ADDR_W] (1=direct),
// field=IR[ADDR_W-1:0]. DATA_W must be >= ADDR_W+5.
module acc_cpu_hs #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] AC,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic              Carry,
  output logic              Zero,
  output logic              Overflow,
  output logic              Negative,
  output logic              halted,
  output logic              illegal_op,
  output logic [2:0]        state
);

  localparam int unsigned M = DATA_W - 1;
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD  = 4'h3,
    OP_SUB = 4'h4, OP_MUL  = 4'h5, OP_DIV   = 4'h6, OP_BR   = 4'h7,
    OP_BRZ = 4'h8, OP_BRN  = 4'h9, OP_AND   = 4'hA, OP_OR   = 4'hB,
    OP_XOR = 4'hC, OP_RSVD_D = 4'hD, OP_RSVD_E = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  state_t             st;
  opcode_t            op;
  logic [DATA_W-1:0]  MBR;
  logic [ADDR_W-1:0]  MAR;
  logic [ADDR_W-1:0]  field;
  logic               direct;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_pc;

  assign op        = opcode_t'(IR[DATA_W-1 -: 4]);
  assign field     = IR[ADDR_W-1:0];
  assign direct    = IR[ADDR_W];
  assign state     = st;
  assign mem_addr  = MAR;
  assign mem_wdata = MBR;

  assign br_taken = (op == OP_BR) || ((op == OP_BRZ) && Zero) ||
                    ((op == OP_BRN) && Negative);
  assign br_pc    = br_taken ? field : PC;

  // ALU
  logic [DATA_W:0]          sum, diff;
  logic [2*DATA_W-1:0]      prod;
  logic signed [DATA_W-1:0] dsr, quot;
  logic [DATA_W-1:0]        alu_res;
  logic                     alu_c, alu_v;

  always_comb begin
    sum  = {1'b0, AC} + {1'b0, MBR};
    diff = {1'b0, AC} - {1'b0, MBR};
    prod = {{DATA_W{AC[M]}}, AC} * {{DATA_W{MBR[M]}}, MBR};
    dsr  = (MBR == '0) ? ONE : $signed(MBR);
    quot = $signed(AC) / dsr;
    alu_res = AC;
    alu_c   = Carry;
    alu_v   = Overflow;
    case (op)
      OP_LOAD: alu_res = MBR;
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (AC[M] == MBR[M]) && (sum[M] != AC[M]);
      end
      OP_SUB: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = diff[DATA_W];
        alu_v   = (AC[M] != MBR[M]) && (diff[M] != AC[M]);
      end
      OP_MUL: begin
        alu_res = prod[DATA_W-1:0];
        alu_c   = 1'b0;
        // in range only when the upper half is a sign extension of bit M
        alu_v   = !((&prod[2*DATA_W-1:M]) || (~|prod[2*DATA_W-1:M]));
      end
      OP_DIV: begin
        alu_c = 1'b0;
        if (MBR == '0) begin
          alu_res = '1;
          alu_v   = 1'b1;
        end else if ((AC == SMIN) && (MBR == '1)) begin
          alu_res = SMIN;
          alu_v   = 1'b1;
        end else begin
          alu_res = quot;
          alu_v   = 1'b0;
        end
      end
      OP_AND: begin alu_res = AC & MBR; alu_c = 1'b0; alu_v = 1'b0; end
      OP_OR:  begin alu_res = AC | MBR; alu_c = 1'b0; alu_v = 1'b0; end
      OP_XOR: begin alu_res = AC ^ MBR; alu_c = 1'b0; alu_v = 1'b0; end
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Transitions into FETCH/OPERAND/WRITE pre-issue the request so a
  // zero-wait memory acks in the state's first cycle. WRITE->FETCH does not
  // pre-issue: mem_req drops for a cycle after every acked transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= ST_FETCH;
      PC       <= RESET_PC;
      AC       <= '0;
      IR       <= '0;
      MBR      <= '0;
      MAR      <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      Zero     <= 1'b1;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Negative <= 1'b0;
      halted   <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (st)
        ST_FETCH: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            MAR     <= PC;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            IR      <= mem_rdata;
            PC      <= PC + 1'b1;
            st      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          MAR <= field;
          case (op)
            OP_BR, OP_BRZ, OP_BRN: begin
              PC      <= br_pc;
              MAR     <= br_pc;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              st      <= ST_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              st     <= ST_HALT;
            end
            OP_STORE: begin
              MBR     <= AC;
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
              st      <= ST_WRITE;
            end
            OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR: begin
              if (direct) begin
                mem_req <= 1'b1;
                mem_we  <= 1'b0;
                st      <= ST_OPERAND;
              end else begin
                MBR <= {{(DATA_W-ADDR_W){1'b0}}, field};
                st  <= ST_EXEC;
              end
            end
`ifdef ILLEGAL_TRAP_EN
            OP_RSVD_D, OP_RSVD_E: begin
              halted    <= 1'b1;
              illegal_q <= 1'b1;
              st        <= ST_HALT;
            end
`endif
            default: begin
              MAR     <= PC;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              st      <= ST_FETCH;
            end
          endcase
        end
        ST_OPERAND: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            MBR     <= mem_rdata;
            st      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          AC       <= alu_res;
          Carry    <= alu_c;
          Overflow <= alu_v;
          Zero     <= (alu_res == '0);
          Negative <= alu_res[M];
          MAR      <= PC;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          st       <= ST_FETCH;
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            st      <= ST_FETCH;
          end
        end
        ST_HALT: st <= ST_HALT;
        default: st <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_hs.sv
`timescale 1ns/1ps
module tb_acc_cpu_hs;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [10:0] mem_addr, PC;
  logic [15:0] mem_wdata, mem_rdata, AC, IR;
  logic        Carry, Zero, Overflow, Negative, halted, illegal_op;
  logic [2:0]  state;

  acc_cpu_hs #(.DATA_W(16), .ADDR_W(11), .RESET_PC(11'd0)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .AC(AC), .PC(PC), .IR(IR),
    .Carry(Carry), .Zero(Zero), .Overflow(Overflow), .Negative(Negative),
    .halted(halted), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] ac; logic [3:0] f; } ex_t;  // f={C,Z,V,N}
  typedef struct packed { logic [10:0] a; logic [15:0] d; } wr_t;

  ex_t         ex_q[$];
  wr_t         wr_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] prog [0:2047];
  logic [15:0] wmem [0:2047];
  int          waits = 0;
  int          cnt = 0;
  int          wr_count = 0;
  int          last_wr_len = 0;
  logic [27:0] lat;
  logic        was_exec = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory responder plus scoreboard monitors (writes and EXEC results).
  always @(negedge clk) begin
    ex_t e;
    wr_t w;
    if (!reset_n) begin
      was_exec = 1'b0;
      cnt      = 0;
      mem_ack  = 1'b0;
    end else begin
      if (was_exec) begin
        chk("ex_pending", 32'(ex_q.size() != 0), 32'd1);
        if (ex_q.size() != 0) begin
          e = ex_q.pop_front();
          chk("ex_ac", 32'(AC), 32'(e.ac));
          chk("ex_flags", 32'({Carry, Zero, Overflow, Negative}), 32'(e.f));
        end
      end
      was_exec = (state == 3'd3);
      if (!mem_req) begin
        cnt     = 0;
        mem_ack = 1'b0;
      end else begin
        if (cnt == 0) lat = {mem_we, mem_addr, mem_wdata};
        else chk("hs_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(lat));
        if (cnt == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = prog[mem_addr];
          if (mem_we) begin
            wmem[mem_addr] = mem_wdata;
            wr_count++;
            last_wr_len = cnt + 1;
            chk("wr_pending", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
              w = wr_q.pop_front();
              chk("wr_addr", 32'(mem_addr), 32'(w.a));
              chk("wr_data", 32'(mem_wdata), 32'(w.d));
            end
          end
        end else begin
          mem_ack = 1'b0;
        end
        cnt++;
      end
    end
  end

  task automatic fill();
    for (int i = 0; i < 2048; i++) prog[i] = 16'hF000;
  endtask

  task automatic push_ex(input logic [15:0] ac, input logic [3:0] f);
    ex_q.push_back('{ac: ac, f: f});
  endtask

  task automatic restart();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_halt(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (halted) begin ok = 1'b1; break; end
    end
    chk({nm, "_halted"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int reqs;
    logic found;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // Program 1: LOAD #5, ADD #3, HALT; zero-wait
    fill();
    prog[0] = 16'h1005; prog[1] = 16'h3003; prog[2] = 16'hF000;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_ac", 32'(AC), 32'd0);
    chk("rst_ir", 32'(IR), 32'd0);
    chk("rst_req_we", 32'({mem_req, mem_we}), 32'd0);
    chk("rst_addr_wdata", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("rst_flags", 32'({Carry, Zero, Overflow, Negative}), 32'b0100);
    chk("rst_halt_ill", 32'({halted, illegal_op}), 32'd0);
    push_ex(16'h0005, 4'b0000);
    push_ex(16'h0008, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_halt("p1");
    chk("p1_pc", 32'(PC), 32'd3);
    chk("p1_ac", 32'(AC), 32'h0008);
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    chk("halt_no_req", 32'(reqs), 32'd0);

    // Program 2: signed overflow, LOAD keeps C/V, BRZ taken then not taken
    fill();
    prog[0] = 16'h1900; prog[1] = 16'h3001; prog[2] = 16'h4001;
    prog[3] = 16'h1001; prog[4] = 16'h4001; prog[5] = 16'h8020;
    prog[11'h20] = 16'h1002; prog[11'h21] = 16'h8030;
    prog[11'h22] = 16'h2040; prog[11'h23] = 16'hF000;
    prog[11'h100] = 16'h7FFF;
    push_ex(16'h7FFF, 4'b0000);
    push_ex(16'h8000, 4'b0011);
    push_ex(16'h7FFF, 4'b0010);
    push_ex(16'h0001, 4'b0010);
    push_ex(16'h0000, 4'b0100);
    push_ex(16'h0002, 4'b0000);
    wr_q.push_back('{a: 11'h040, d: 16'h0002});
    restart();
    wait_halt("p2");
    chk("p2_pc", 32'(PC), 32'h24);

    // Program 3: 3 wait states, direct LOAD 0x1234 then STORE 0x40
    waits = 3;
    fill();
    prog[0] = 16'h1901; prog[1] = 16'h2040; prog[2] = 16'hF000;
    prog[11'h101] = 16'h1234;
    push_ex(16'h1234, 4'b0000);
    wr_q.push_back('{a: 11'h040, d: 16'h1234});
    base = wr_count;
    restart();
    wait_halt("p3");
    chk("p3_wr_count", 32'(wr_count - base), 32'd1);
    chk("p3_wr_len", 32'(last_wr_len), 32'd4);
    chk("p3_wmem", 32'(wmem[11'h040]), 32'h1234);
    chk("p3_pc", 32'(PC), 32'd3);

    // Program 4: DIV/MUL corners, logic ops, BRN, reserved opcode
    waits = 0;
    fill();
    prog[0] = 16'h1902; prog[1] = 16'h6903; prog[2] = 16'h6904;
    prog[3] = 16'h1905; prog[4] = 16'h6906; prog[5] = 16'h1100;
    prog[6] = 16'h5100; prog[7] = 16'h10F0; prog[8] = 16'hA03C;
    prog[9] = 16'hB00F; prog[10] = 16'hC03F; prog[11] = 16'h9050;
    prog[12] = 16'h4001; prog[13] = 16'h9050;
    prog[11'h50] = 16'hD000; prog[11'h51] = 16'hF000;
    prog[11'h102] = 16'hFFF9; prog[11'h103] = 16'h0002; prog[11'h104] = 16'h0000;
    prog[11'h105] = 16'h8000; prog[11'h106] = 16'hFFFF;
    push_ex(16'hFFF9, 4'b0001);
    push_ex(16'hFFFD, 4'b0001);
    push_ex(16'hFFFF, 4'b0011);
    push_ex(16'h8000, 4'b0011);
    push_ex(16'h8000, 4'b0011);
    push_ex(16'h0100, 4'b0010);
    push_ex(16'h0000, 4'b0110);
    push_ex(16'h00F0, 4'b0010);
    push_ex(16'h0030, 4'b0000);
    push_ex(16'h003F, 4'b0000);
    push_ex(16'h0000, 4'b0100);
    push_ex(16'hFFFF, 4'b1001);
    restart();
    wait_halt("p4");
    chk("p4_ac", 32'(AC), 32'hFFFF);
`ifdef ILLEGAL_TRAP_EN
    chk("p4_pc", 32'(PC), 32'h51);
    chk("p4_illegal", 32'(illegal_op), 32'd1);
`else
    chk("p4_pc", 32'(PC), 32'h52);
    chk("p4_illegal", 32'(illegal_op), 32'd0);
`endif

    // Program 5: async reset while OPERAND request is outstanding
    waits = 3;
    fill();
    prog[0] = 16'h1005; prog[1] = 16'h1900; prog[2] = 16'hF000;
    prog[11'h100] = 16'h0777;
    push_ex(16'h0005, 4'b0000);
    restart();
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state == 3'd2 && mem_req) begin found = 1'b1; break; end
    end
    chk("p5_in_operand", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("p5_req_async", 32'(mem_req), 32'd0);
    chk("p5_pc", 32'(PC), 32'd0);
    chk("p5_zero", 32'(Zero), 32'd1);
    chk("p5_state", 32'(state), 32'd0);
    push_ex(16'h0005, 4'b0000);
    push_ex(16'h0777, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_halt("p5");
    chk("p5_end_pc", 32'(PC), 32'd3);
    chk("p5_end_ac", 32'(AC), 32'h0777);

    repeat (2) @(negedge clk);
    chk("ex_q_drained", 32'(ex_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
